// File: rtl/range_session_ctrl.sv
// Session sequencer for the min/max range finder: feeds a window of samples,
// sequences go/finish with legal timing and holds the captured range for the consumer.
module range_session_ctrl #(
   parameter int WIDTH     = 16,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] win_len,
   input  logic                 abort,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 in_ready,
   output logic [WIDTH-1:0]     rf_data,
   output logic                 rf_go,
   output logic                 rf_finish,
   input  logic [WIDTH-1:0]     rf_range,
   input  logic                 rf_error,
   output logic [WIDTH-1:0]     result,
   output logic                 result_valid,
   input  logic                 result_ready,
   output logic                 busy,
   output logic                 aborted,
   output logic                 cfg_err,
   output logic                 err_sticky,
   output logic [2:0]           state_dbg
);

   // Both ports use valid/ready: a transfer happens on the rising edge where
   // valid && ready are both high; valid never depends on ready.

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RUN     = 3'd1,
      S_DRAIN   = 3'd2,
      S_FINISH  = 3'd3,
      S_CAPTURE = 3'd4,
      S_HOLD    = 3'd5
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] len_q, len_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 abort_pend_q, abort_pend_d;
   logic [WIDTH-1:0]     rf_data_q, rf_data_d;
   logic                 rf_go_q, rf_go_d;
   logic                 rf_finish_q, rf_finish_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 result_valid_q, result_valid_d;
   logic                 aborted_q, aborted_d;
   logic                 cfg_err_q, cfg_err_d;
   logic                 err_sticky_q, err_sticky_d;

   logic accept;
   logic start_ok;
   logic last_sample;

   assign in_ready    = (state_q == S_RUN) && !abort;
   assign accept      = in_valid && in_ready;
   assign start_ok    = (state_q == S_IDLE) && start && (win_len != '0);
   assign last_sample = accept && ((cnt_q + CNT_ONE) == len_q);

   assign rf_data      = rf_data_q;
   assign rf_go        = rf_go_q;
   assign rf_finish    = rf_finish_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign busy         = (state_q != S_IDLE);
   assign aborted      = aborted_q;
   assign cfg_err      = cfg_err_q;
   assign err_sticky   = err_sticky_q;
   assign state_dbg    = state_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start_ok) state_d = S_RUN;
         S_RUN: begin
            // An abort with nothing loaded skips the finish handshake entirely.
            if (abort)            state_d = (cnt_q == '0) ? S_IDLE : S_FINISH;
            else if (last_sample) state_d = S_DRAIN;
         end
         S_DRAIN:   state_d = S_FINISH;
         S_FINISH:  state_d = abort_pend_q ? S_IDLE : S_CAPTURE;
         S_CAPTURE: state_d = S_HOLD;
         S_HOLD:    if (result_ready) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      len_d          = len_q;
      cnt_d          = cnt_q;
      abort_pend_d   = abort_pend_q;
      rf_data_d      = rf_data_q;
      rf_go_d        = rf_go_q;
      rf_finish_d    = rf_finish_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      aborted_d      = 1'b0;
      cfg_err_d      = 1'b0;
      err_sticky_d   = err_sticky_q | (rf_error && busy);
      case (state_q)
         S_IDLE: begin
            cfg_err_d = start && (win_len == '0);
            if (start_ok) begin
               len_d        = win_len;
               cnt_d        = '0;
               abort_pend_d = 1'b0;
               err_sticky_d = 1'b0;
            end
         end
         S_RUN: begin
            if (abort) begin
               if (cnt_q == '0) begin
                  aborted_d = 1'b1;
               end else begin
                  rf_go_d      = 1'b0;
                  rf_finish_d  = 1'b1;
                  abort_pend_d = 1'b1;
               end
            end else if (accept) begin
               // rf_data keeps the last sample between acceptances; min/max is idempotent.
               rf_data_d = in_data;
               rf_go_d   = 1'b1;
               cnt_d     = cnt_q + CNT_ONE;
            end
         end
         S_DRAIN: begin
            rf_go_d     = 1'b0;
            rf_finish_d = 1'b1;
         end
         S_FINISH: begin
            rf_finish_d = 1'b0;
            aborted_d   = abort_pend_q;
         end
         S_CAPTURE: begin
            result_d       = rf_range;
            result_valid_d = 1'b1;
         end
         S_HOLD: begin
            if (result_ready) result_valid_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         len_q          <= '0;
         cnt_q          <= '0;
         abort_pend_q   <= 1'b0;
         rf_data_q      <= '0;
         rf_go_q        <= 1'b0;
         rf_finish_q    <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         aborted_q      <= 1'b0;
         cfg_err_q      <= 1'b0;
         err_sticky_q   <= 1'b0;
      end else begin
         len_q          <= len_d;
         cnt_q          <= cnt_d;
         abort_pend_q   <= abort_pend_d;
         rf_data_q      <= rf_data_d;
         rf_go_q        <= rf_go_d;
         rf_finish_q    <= rf_finish_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         aborted_q      <= aborted_d;
         cfg_err_q      <= cfg_err_d;
         err_sticky_q   <= err_sticky_d;
      end
   end

endmodule

// File: tb/tb_range_session_ctrl.sv
// Directed bench for range_session_ctrl: a behavioural range finder feeds rf_range,
// and a session-timeline model predicts every output for a per-cycle compare.
module tb_range_session_ctrl;

   localparam int WIDTH = 16;
   localparam int CNT_WIDTH = 8;

   logic                 clock;
   logic                 reset;
   logic                 start;
   logic [CNT_WIDTH-1:0] win_len;
   logic                 abort;
   logic                 in_valid;
   logic [WIDTH-1:0]     in_data;
   logic                 in_ready;
   logic [WIDTH-1:0]     rf_data;
   logic                 rf_go;
   logic                 rf_finish;
   logic [WIDTH-1:0]     rf_range;
   logic                 rf_error;
   logic [WIDTH-1:0]     result;
   logic                 result_valid;
   logic                 result_ready;
   logic                 busy;
   logic                 aborted;
   logic                 cfg_err;
   logic                 err_sticky;
   logic [2:0]           state_dbg;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;
   logic err_inj = 1'b0;

   range_session_ctrl #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clock(clock), .reset(reset), .start(start), .win_len(win_len), .abort(abort),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .rf_data(rf_data), .rf_go(rf_go), .rf_finish(rf_finish),
      .rf_range(rf_range), .rf_error(rf_error),
      .result(result), .result_valid(result_valid), .result_ready(result_ready),
      .busy(busy), .aborted(aborted), .cfg_err(cfg_err), .err_sticky(err_sticky),
      .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   // ---------------- behavioural range finder ----------------
   logic [WIDTH-1:0] rfm_min, rfm_max, rfm_range;
   logic             rfm_act;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         rfm_min <= '0; rfm_max <= '0; rfm_range <= '0; rfm_act <= 1'b0;
      end else if (rf_finish) begin
         rfm_range <= rfm_max - rfm_min;
         rfm_act   <= 1'b0;
      end else if (rf_go) begin
         rfm_act <= 1'b1;
         if (!rfm_act || rf_data < rfm_min) rfm_min <= rf_data;
         if (!rfm_act || rf_data > rfm_max) rfm_max <= rf_data;
      end
   end

   assign rf_range = rfm_range;
   assign rf_error = (rf_finish && (rf_go || !rfm_act)) || err_inj;

   // ---------------- session timeline model ----------------
   logic [WIDTH-1:0] m_q[$];
   logic [WIDTH-1:0] m_last, m_result;
   logic             m_active, m_abort_fin, m_rv, m_aborted, m_cfg, m_err;
   int               m_len, m_since;
   logic             m_busy;

   assign m_busy = m_active || (m_since != 0) || m_abort_fin || m_rv;

   function automatic logic [WIDTH-1:0] range_of(input logic [WIDTH-1:0] q[$]);
      logic [WIDTH-1:0] lo, hi;
      lo = q[0];
      hi = q[0];
      foreach (q[i]) begin
         if (q[i] < lo) lo = q[i];
         if (q[i] > hi) hi = q[i];
      end
      return hi - lo;
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_q.delete();
         m_last <= '0; m_result <= '0; m_active <= 1'b0; m_abort_fin <= 1'b0;
         m_rv <= 1'b0; m_aborted <= 1'b0; m_cfg <= 1'b0; m_err <= 1'b0;
         m_len <= 0; m_since <= 0;
      end else begin
         m_aborted <= 1'b0;
         m_cfg     <= 1'b0;
         if (m_busy && rf_error) m_err <= 1'b1;
         if (!m_busy && start) begin
            if (win_len == 0) m_cfg <= 1'b1;
            else begin
               m_active <= 1'b1;
               m_len    <= int'(win_len);
               m_err    <= 1'b0;
               m_q.delete();
            end
         end
         if (m_active) begin
            if (abort) begin
               m_active <= 1'b0;
               if (m_q.size() != 0) m_abort_fin <= 1'b1;
               else m_aborted <= 1'b1;
            end else if (in_valid) begin
               m_last <= in_data;
               if (m_q.size() + 1 == m_len) begin
                  m_active <= 1'b0;
                  m_since  <= 1;
               end
               m_q.push_back(in_data);
            end
         end
         if (m_abort_fin) begin
            m_abort_fin <= 1'b0;
            m_aborted   <= 1'b1;
         end
         if (m_since == 3) begin
            m_since  <= 0;
            m_rv     <= 1'b1;
            m_result <= range_of(m_q);
         end else if (m_since != 0) begin
            m_since <= m_since + 1;
         end
         if (m_rv && result_ready) m_rv <= 1'b0;
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (chk_en && !reset) begin
         check("in_ready", 32'(in_ready), 32'(m_active && !abort));
         check("rf_go", 32'(rf_go), 32'((m_active && m_q.size() != 0) || m_since == 1));
         check("rf_finish", 32'(rf_finish), 32'(m_since == 2 || m_abort_fin));
         check("rf_data", 32'(rf_data), 32'(m_last));
         check("busy", 32'(busy), 32'(m_busy));
         check("result_valid", 32'(result_valid), 32'(m_rv));
         check("result", 32'(result), 32'(m_result));
         check("aborted", 32'(aborted), 32'(m_aborted));
         check("cfg_err", 32'(cfg_err), 32'(m_cfg));
         check("err_sticky", 32'(err_sticky), 32'(m_err));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_start(input logic [CNT_WIDTH-1:0] len);
      start   = 1'b1;
      win_len = len;
      tick();
      start   = 1'b0;
   endtask

   task automatic send(input logic [WIDTH-1:0] d, input int gap);
      logic r;
      int   n;
      in_valid = 1'b1;
      in_data  = d;
      n = 0;
      r = 1'b0;
      while (!r && n < 50) begin
         @(negedge clock);
         r = in_ready;
         tick();
         n++;
      end
      if (!r) check("send_timeout", 0, 1);
      in_valid = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (!result_valid && lat < 50) begin
         tick();
         lat++;
      end
      if (!result_valid) check("result_timeout", 0, 1);
   endtask

   task automatic pop();
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int lat;
      reset = 1'b1; start = 1'b0; win_len = '0; abort = 1'b0;
      in_valid = 1'b0; in_data = '0; result_ready = 1'b0;
      repeat (3) tick();
      check("rst_busy", 32'(busy), 0);
      check("rst_rf_go", 32'(rf_go), 0);
      check("rst_result_valid", 32'(result_valid), 0);
      reset = 1'b0;
      chk_en = 1'b1;
      tick();

      // 10,3,25,7 continuous: range 22, valid three edges after the last accept
      do_start(8'd4);
      send(16'd10, 0); send(16'd3, 0); send(16'd25, 0); send(16'd7, 0);
      wait_result(lat);
      check("t1_latency", 32'(lat), 3);
      check("t1_result", 32'(result), 22);
      check("t1_err_sticky", 32'(err_sticky), 0);
      pop();

      // single sample: DRAIN keeps go, then a lone finish cycle
      do_start(8'd1);
      send(16'h1234, 0);
      check("t2_drain_go", 32'(rf_go), 1);
      check("t2_drain_fin", 32'(rf_finish), 0);
      tick();
      check("t2_finish_go", 32'(rf_go), 0);
      check("t2_finish_fin", 32'(rf_finish), 1);
      wait_result(lat);
      check("t2_result", 32'(result), 0);
      pop();

      // gaps between samples: go stays high while idle
      do_start(8'd3);
      send(16'hFFFF, 2);
      check("t3_gap_go", 32'(rf_go), 1);
      send(16'h0000, 2);
      send(16'h8000, 0);
      wait_result(lat);
      check("t3_result", 32'(result), 32'hFFFF);
      pop();

      // abort after two samples, then a clean session
      do_start(8'd5);
      send(16'd40, 0); send(16'd60, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t4_abort_fin", 32'(rf_finish), 1);
      tick();
      check("t4_aborted", 32'(aborted), 1);
      check("t4_no_result", 32'(result_valid), 0);
      repeat (2) tick();
      do_start(8'd2);
      send(16'd5, 0); send(16'd9, 0);
      wait_result(lat);
      check("t4_result", 32'(result), 4);
      pop();

      // abort before any sample, abort colliding with a valid sample
      do_start(8'd3);
      in_valid = 1'b1; in_data = 16'hABCD; abort = 1'b1;
      tick();
      in_valid = 1'b0; abort = 1'b0;
      check("t4b_aborted", 32'(aborted), 1);
      check("t4b_rf_data", 32'(rf_data), 9);

      // result held under back-pressure; start ignored; injected rf_error latches
      do_start(8'd2);
      send(16'd1, 0);
      err_inj = 1'b1;
      tick();
      err_inj = 1'b0;
      send(16'd100, 0);
      wait_result(lat);
      check("t5_err_sticky", 32'(err_sticky), 1);
      for (int i = 0; i < 6; i++) begin
         start = i[0]; win_len = 8'd3;
         tick();
         check("t5_busy", 32'(busy), 1);
         check("t5_result", 32'(result), 99);
      end
      start = 1'b0;
      pop();
      check("t5_idle", 32'(busy), 0);
      do_start(8'd1);
      check("t5_restart_busy", 32'(busy), 1);
      check("t5_err_cleared", 32'(err_sticky), 0);
      send(16'd7, 0);
      wait_result(lat);
      check("t5b_result", 32'(result), 0);
      pop();

      // zero-length window request
      do_start(8'd0);
      check("t6_cfg_err", 32'(cfg_err), 1);
      check("t6_busy", 32'(busy), 0);
      tick();
      check("t6_cfg_err_clr", 32'(cfg_err), 0);
      check("t6_rf_go", 32'(rf_go), 0);

      // asynchronous reset in the middle of a run
      do_start(8'd3);
      send(16'd11, 0);
      @(posedge clock);
      #3;
      reset = 1'b1;
      #1;
      check("t7_rf_go", 32'(rf_go), 0);
      check("t7_rf_data", 32'(rf_data), 0);
      check("t7_busy", 32'(busy), 0);
      check("t7_result", 32'(result), 0);
      check("t7_in_ready", 32'(in_ready), 0);
      tick();
      reset = 1'b0;
      tick();
      do_start(8'd2);
      send(16'd5, 0); send(16'd9, 0);
      wait_result(lat);
      check("t7_result_after", 32'(result), 4);
      pop();
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
